mr1_mem_arbiter: RTL
====================

Name: mr1_mem_arbiter

Overview:
- Shares one memory port between the MR1 instruction-fetch bus and the MR1 data bus.
- Arbitrates requests, holds the grant stable while the memory stalls, tracks outstanding reads in order, and routes each read response back to its requester.
- Sits between MR1 and the single-ported memory/interconnect.
- The formal wrapper drives its mem side with random ready/valid, constrained to in-order responses.

Parameters:
- MAX_OUTSTANDING, 4, max reads in flight (source-tag FIFO depth, power of 2, >=2).
- STARVE_LIMIT, 3, consecutive cycles instr may be denied before it gets priority over data.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- instr_req_valid  in  1  fetch request
- instr_req_ready  out  1  fetch accepted
- instr_req_addr  in  32  fetch address
- instr_rsp_valid  out  1  fetch data valid
- instr_rsp_data  out  32  fetch data
- data_req_valid  in  1  load/store request
- data_req_ready  out  1  load/store accepted
- data_req_wr  in  1  1 = store
- data_req_addr  in  32  load/store address
- data_req_size  in  2  0 = byte, 1 = half, 2 = word
- data_req_data  in  32  store data
- data_rsp_valid  out  1  load data valid
- data_rsp_data  out  32  load data
- mem_req_valid  out  1  shared request
- mem_req_ready  in  1  memory accepts
- mem_req_wr  out  1  store
- mem_req_addr  out  32  address
- mem_req_size  out  2  size
- mem_req_data  out  32  store data
- mem_rsp_valid  in  1  read data valid, in order
- mem_rsp_data  in  32  read data
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads in flight
- err_unexpected_rsp  out  1  sticky: mem_rsp_valid seen with no read in flight

Behaviour:
- Reset (async assert, released on clk):
  - Tag FIFO empty, outstanding=0, lock cleared, starve counter=0, err_unexpected_rsp=0.
  - All *_valid/ready outputs 0 while reset is high.
- Grant selection each cycle:
  - If lock is set, grant = locked_src.
  - Else if data_req_valid and starve_cnt<STARVE_LIMIT, grant data.
  - Else if instr_req_valid, grant instr.
  - Else if data_req_valid, grant data.
- Blocking: when the FIFO is full, any grant that would issue a read is blocked. Its mem_req_valid=0 and the requester's ready=0.
  - Data stores are never blocked by full.
  - Full blocks even if mem_rsp_valid pops in the same cycle; there is no rsp->ready path.
- Request path (combinational): mem_req_* = fields of the granted requester.
  - For instr: wr=0, size=2, data=0.
  - Granted requester ready = mem_req_ready & ~blocked; the other requester's ready = 0.
  - No comb path from mem_req_ready to mem_req_valid.
- Lock: set when mem_req_valid & ~mem_req_ready, recording locked_src; cleared on handshake.
  - Requesters hold valid and fields stable until ready (MR1 bus rule). Verification asserts mem_req_* stable while stalled.
- Starvation: starve_cnt increments (saturating at STARVE_LIMIT) while instr_req_valid and instr is not handshaked; clears on an instr handshake.
- Tag FIFO: push on a read handshake (tag 0 = instr, 1 = data). Pop on mem_rsp_valid when non-empty. Simultaneous push/pop keeps the count; pointers wrap modulo depth.
- Response path (combinational, zero latency):
  - instr_rsp_valid = mem_rsp_valid & ~empty & head==0.
  - data_rsp_valid = mem_rsp_valid & ~empty & head==1.
  - Both rsp_data = mem_rsp_data.
- Unexpected response: mem_rsp_valid with the FIFO empty is dropped and sets err_unexpected_rsp until reset.
- Reset mid-operation: all in-flight tags are discarded. Responses arriving after reset for pre-reset reads count as unexpected.
- Stores produce no response and do not touch the FIFO or outstanding.

Decomposition:
- Package mr1_mem_pkg: src_t enum (SRC_INSTR=0, SRC_DATA=1), size constants SIZE_B/H/W, req_t struct {wr, addr, size, data}.
- Sub-module mr1_tag_fifo: parameterised 1-bit sync FIFO with full, empty and count.
- The arbiter owns grant, lock and starvation logic.

Test Plan:
- Only instr valid, addr 0x100; mem_req_ready=1; mem_rsp 0xDEADBEEF two cycles later -> instr_rsp_valid=1 with 0xDEADBEEF, data_rsp_valid=0, outstanding 1->0.
- Both valid continuously, data loads, ready=1, STARVE_LIMIT=3 -> grants data,data,data,instr repeating. Responses route by tag in the same order.
- Data store 0x200 size 0 stalled 3 cycles by ready=0, instr valid meanwhile -> mem_req_* stay constant (wr=1, addr 0x200) until ready; instr not granted; outstanding stays 0.
- Issue 4 instr reads with no responses -> 5th request sees instr_req_ready=0, outstanding=4. One response -> next cycle the 5th is accepted.
- mem_rsp_valid with the FIFO empty -> no rsp_valid on either side, err_unexpected_rsp=1 and held.
- Assert reset with 2 reads in flight -> outstanding=0 and all outputs 0 immediately. A response after release sets err_unexpected_rsp.

Source files
------------

// File: rtl/mr1_mem_pkg.sv
// Shared types for the MR1 memory arbiter: request source tags, access sizes
// and the request field bundle.
package mr1_mem_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
  } req_t;

endpackage

// File: rtl/mr1_tag_fifo.sv
// Source-tag FIFO: remembers which requester issued each in-flight read so
// in-order responses can be routed back.
module mr1_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    push_tag,
  input  logic                    pop,
  output logic                    head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] tags;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = tags[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tags   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        tags[wr_ptr] <= push_tag;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mr1_mem_arbiter.sv
// Shares one memory port between MR1 instruction fetch and data access:
// grant/lock/starvation control plus in-order read response routing.
module mr1_mem_arbiter
  import mr1_mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               instr_req_valid,
  output logic                               instr_req_ready,
  input  logic [31:0]                        instr_req_addr,
  output logic                               instr_rsp_valid,
  output logic [31:0]                        instr_rsp_data,
  input  logic                               data_req_valid,
  output logic                               data_req_ready,
  input  logic                               data_req_wr,
  input  logic [31:0]                        data_req_addr,
  input  logic [1:0]                         data_req_size,
  input  logic [31:0]                        data_req_data,
  output logic                               data_rsp_valid,
  output logic [31:0]                        data_rsp_data,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic                               mem_req_wr,
  output logic [31:0]                        mem_req_addr,
  output logic [1:0]                         mem_req_size,
  output logic [31:0]                        mem_req_data,
  input  logic                               mem_rsp_valid,
  input  logic [31:0]                        mem_rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_unexpected_rsp
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Handshake: a transfer happens on a cycle where valid & ready are both
  // high; valid never depends on ready, and a stalled request keeps valid
  // and its fields stable until accepted.

  req_t          instr_req;
  req_t          data_req;
  req_t          gnt_req;
  src_t          grant;
  src_t          locked_src;
  logic          lock;
  logic [SW-1:0] starve_cnt;
  logic          grant_active;
  logic          grant_is_read;
  logic          blocked;
  logic          mem_hs;
  logic          instr_hs;
  logic          fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          rsp_ok;

  assign instr_req = '{wr: 1'b0, addr: instr_req_addr, size: SIZE_W, data: 32'd0};
  assign data_req  = '{wr: data_req_wr, addr: data_req_addr,
                       size: data_req_size, data: data_req_data};

  always_comb begin
    grant = SRC_DATA;
    if (lock) begin
      grant = locked_src;
    end else if (data_req_valid && (starve_cnt < STARVE_MAX)) begin
      grant = SRC_DATA;
    end else if (instr_req_valid) begin
      grant = SRC_INSTR;
    end else begin
      grant = SRC_DATA;
    end
  end

  assign grant_active  = (grant == SRC_INSTR) ? instr_req_valid : data_req_valid;
  assign gnt_req       = (grant == SRC_INSTR) ? instr_req : data_req;
  assign grant_is_read = ~gnt_req.wr;

  // Reads stall on a full tag FIFO; stores carry no tag and always proceed.
  assign blocked = grant_active & grant_is_read & fifo_full;

  assign mem_req_valid = grant_active & ~blocked & ~reset;
  assign mem_req_wr    = gnt_req.wr;
  assign mem_req_addr  = gnt_req.addr;
  assign mem_req_size  = gnt_req.size;
  assign mem_req_data  = gnt_req.data;

  assign instr_req_ready = (grant == SRC_INSTR) & mem_req_ready & ~blocked & ~reset;
  assign data_req_ready  = (grant == SRC_DATA) & mem_req_ready & ~blocked & ~reset;

  assign mem_hs   = mem_req_valid & mem_req_ready;
  assign instr_hs = instr_req_valid & instr_req_ready;

  mr1_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (mem_hs & grant_is_read),
    .push_tag (logic'(grant)),
    .pop      (mem_rsp_valid),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outstanding)
  );

  assign rsp_ok          = mem_rsp_valid & ~fifo_empty & ~reset;
  assign instr_rsp_valid = rsp_ok & (src_t'(fifo_head) == SRC_INSTR);
  assign data_rsp_valid  = rsp_ok & (src_t'(fifo_head) == SRC_DATA);
  assign instr_rsp_data  = mem_rsp_data;
  assign data_rsp_data   = mem_rsp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock               <= 1'b0;
      locked_src         <= SRC_INSTR;
      starve_cnt         <= '0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      if (mem_req_valid && !mem_req_ready) begin
        lock       <= 1'b1;
        locked_src <= grant;
      end else if (mem_hs) begin
        lock <= 1'b0;
      end

      if (instr_hs) begin
        starve_cnt <= '0;
      end else if (instr_req_valid && (starve_cnt < STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (mem_rsp_valid && fifo_empty) begin
        err_unexpected_rsp <= 1'b1;
      end
    end
  end

endmodule
